// File: rtl/siren_generator.sv
// siren_generator: multi-mode square-wave siren for a single piezo pin.
// Modes: off, steady tone, two-tone alternation and linear wail sweep.
module siren_generator #(
  parameter int CLK_HZ       = 16000000,
  parameter int F_LO         = 440,
  parameter int F_HI         = 880,
  parameter int ALT_CYCLES   = 8388608,
  parameter int SWEEP_CYCLES = 4096,
  parameter int SWEEP_STEP   = 4,
  parameter int DIV_W        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [1:0] MODE,
  output logic       AUDIO,
  output logic       ACTIVE,
  output logic       TONE_HI
);

  localparam int DIV_LO = CLK_HZ / F_LO / 2;
  localparam int DIV_HI = CLK_HZ / F_HI / 2;
  localparam int ALT_W  = $clog2(ALT_CYCLES + 1);
  localparam int SWP_W  = $clog2(SWEEP_CYCLES + 1);
  localparam int W1     = DIV_W + 1;

  localparam logic [DIV_W-1:0] LO_D   = DIV_W'(DIV_LO);
  localparam logic [DIV_W-1:0] HI_D   = DIV_W'(DIV_HI);
  localparam logic [W1-1:0]    LO_W   = W1'(DIV_LO);
  localparam logic [W1-1:0]    HI_W   = W1'(DIV_HI);
  localparam logic [W1-1:0]    STEP_W = W1'(SWEEP_STEP);
  localparam logic [ALT_W-1:0] ALT_LAST = ALT_W'(ALT_CYCLES - 1);
  localparam logic [SWP_W-1:0] SWP_LAST = SWP_W'(SWEEP_CYCLES - 1);

  if (DIV_HI < 2) begin : g_chk_hi
    $error("siren_generator: DIV_HI must be >= 2");
  end
  if (DIV_LO <= DIV_HI) begin : g_chk_lo
    $error("siren_generator: DIV_LO must exceed DIV_HI");
  end
  if (DIV_LO >= (2 ** DIV_W)) begin : g_chk_w
    $error("siren_generator: DIV_LO does not fit in DIV_W bits");
  end
  if (SWEEP_STEP < 1) begin : g_chk_step
    $error("siren_generator: SWEEP_STEP must be >= 1");
  end
  if (ALT_CYCLES < 1) begin : g_chk_alt
    $error("siren_generator: ALT_CYCLES must be >= 1");
  end
  if (SWEEP_CYCLES < 1) begin : g_chk_swp
    $error("siren_generator: SWEEP_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEADY,
    S_TWO_LO,
    S_TWO_HI,
    S_WAIL_UP,
    S_WAIL_DN
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       req_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] div_d;
  logic [ALT_W-1:0] alt_q, alt_d;
  logic [SWP_W-1:0] swp_q, swp_d;
  logic             audio_q, audio_d;
  logic             active_q, tone_hi_q;
  logic             restart, go;
  logic [W1-1:0]    cur_w, dn_w, up_w;

  assign restart = ({EN, MODE} != req_q);
  assign go      = EN && (MODE != 2'd0);
  assign cur_w   = {1'b0, cur_div_q};
  assign dn_w    = cur_w - STEP_W;
  assign up_w    = cur_w + STEP_W;

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    cnt_d     = cnt_q;
    alt_d     = alt_q;
    swp_d     = swp_q;
    audio_d   = audio_q;
    div_d     = LO_D;
    if (!go) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      alt_d   = '0;
      swp_d   = '0;
      audio_d = 1'b0;
    end else if (restart || state_q == S_IDLE) begin
      // every entry state starts on the low divider
      unique case (MODE)
        2'd1:    state_d = S_STEADY;
        2'd2:    state_d = S_TWO_LO;
        default: begin
          state_d   = S_WAIL_UP;
          cur_div_d = LO_D;
        end
      endcase
      cnt_d   = LO_D - DIV_W'(1);
      alt_d   = '0;
      swp_d   = '0;
      audio_d = 1'b0;
    end else begin
      unique case (state_q)
        S_TWO_LO, S_TWO_HI: begin
          if (alt_q == ALT_LAST) begin
            alt_d   = '0;
            state_d = (state_q == S_TWO_LO) ? S_TWO_HI : S_TWO_LO;
          end else begin
            alt_d = alt_q + ALT_W'(1);
          end
        end
        S_WAIL_UP: begin
          if (swp_q == SWP_LAST) begin
            swp_d = '0;
            if (cur_w < STEP_W || dn_w <= HI_W) begin
              cur_div_d = HI_D;
              state_d   = S_WAIL_DN;
            end else begin
              cur_div_d = dn_w[DIV_W-1:0];
            end
          end else begin
            swp_d = swp_q + SWP_W'(1);
          end
        end
        S_WAIL_DN: begin
          if (swp_q == SWP_LAST) begin
            swp_d = '0;
            if (up_w >= LO_W) begin
              cur_div_d = LO_D;
              state_d   = S_WAIL_UP;
            end else begin
              cur_div_d = up_w[DIV_W-1:0];
            end
          end else begin
            swp_d = swp_q + SWP_W'(1);
          end
        end
        default: ;
      endcase
      // the divider only takes effect at a reload
      unique case (state_d)
        S_TWO_HI:             div_d = HI_D;
        S_WAIL_UP, S_WAIL_DN: div_d = cur_div_d;
        default:              div_d = LO_D;
      endcase
      if (cnt_q == '0) begin
        audio_d = ~audio_q;
        cnt_d   = div_d - DIV_W'(1);
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      alt_q     <= '0;
      swp_q     <= '0;
      cur_div_q <= LO_D;
      audio_q   <= 1'b0;
      active_q  <= 1'b0;
      tone_hi_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= {EN, MODE};
      cnt_q     <= cnt_d;
      alt_q     <= alt_d;
      swp_q     <= swp_d;
      cur_div_q <= cur_div_d;
      audio_q   <= audio_d;
      active_q  <= (state_d != S_IDLE);
      tone_hi_q <= (state_d == S_TWO_HI) || (state_d == S_WAIL_UP);
    end
  end

  assign AUDIO   = audio_q;
  assign ACTIVE  = active_q;
  assign TONE_HI = tone_hi_q;

endmodule

// File: tb/tb_siren_generator.sv
// tb_siren_generator: scoreboard bench for siren_generator.
// Expected output changes are queued with their cycle; a monitor pops them.
module tb_siren_generator;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [1:0] MODE;
  logic       AUDIO, ACTIVE, TONE_HI;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  typedef struct packed {
    int         c;
    logic [1:0] v;
  } ev_t;

  ev_t q_ctl[$];
  ev_t q_aud[$];
  logic [1:0] ctl_prev = 2'b00;
  logic       aud_prev = 1'b0;

  siren_generator #(
    .CLK_HZ      (1000),
    .F_LO        (50),
    .F_HI        (100),
    .ALT_CYCLES  (40),
    .SWEEP_CYCLES(20),
    .SWEEP_STEP  (1),
    .DIV_W       (16)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .MODE   (MODE),
    .AUDIO  (AUDIO),
    .ACTIVE (ACTIVE),
    .TONE_HI(TONE_HI)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic exp_ctl(input int c, input logic [1:0] v);
    ev_t e;
    e.c = c;
    e.v = v;
    q_ctl.push_back(e);
  endtask

  task automatic exp_aud(input int c, input logic v);
    ev_t e;
    e.c = c;
    e.v = {1'b0, v};
    q_aud.push_back(e);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic chk(input string nm, input logic got, input logic want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b want %b", nm, cyc, got, want);
    end
  endtask

  // monitor: every change of {ACTIVE,TONE_HI} or AUDIO must be expected
  always @(negedge CLK) begin
    ev_t e;
    logic [1:0] ctl;
    ctl = {ACTIVE, TONE_HI};
    if (cyc >= 1) begin
      if (ctl !== ctl_prev) begin
        n_run++;
        if (q_ctl.size() == 0) begin
          n_fail++;
          $display("FAIL ctl unexpected: got %b @cyc %0d", ctl, cyc);
        end else begin
          e = q_ctl.pop_front();
          if (e.c != cyc || e.v !== ctl) begin
            n_fail++;
            $display("FAIL ctl: got %b @cyc %0d want %b @cyc %0d",
                     ctl, cyc, e.v, e.c);
          end
        end
        ctl_prev = ctl;
      end
      if (AUDIO !== aud_prev) begin
        n_run++;
        if (q_aud.size() == 0) begin
          n_fail++;
          $display("FAIL audio unexpected: got %b @cyc %0d", AUDIO, cyc);
        end else begin
          e = q_aud.pop_front();
          if (e.c != cyc || e.v[0] !== AUDIO) begin
            n_fail++;
            $display("FAIL audio: got %b @cyc %0d want %b @cyc %0d",
                     AUDIO, cyc, e.v[0], e.c);
          end
        end
        aud_prev = AUDIO;
      end
    end
  end

  int tt_cyc[17] = '{150, 160, 170, 180, 185, 190, 195, 200, 205,
                     210, 215, 220, 230, 240, 250, 260, 265};
  int wl_off[23] = '{10, 20, 29, 38, 47, 55, 63, 70, 77, 84, 90, 96,
                     102, 107, 112, 117, 122, 128, 134, 140, 147, 154, 161};

  initial begin
    int e0;
    int e2;
    RST  = 1'b1;
    EN   = 1'b0;
    MODE = 2'd0;
    to_cyc(3);
    chk("rst_audio", AUDIO, 1'b0);
    chk("rst_active", ACTIVE, 1'b0);
    chk("rst_tone_hi", TONE_HI, 1'b0);
    RST = 1'b0;

    // silent for 100 cycles: any output change is unexpected
    to_cyc(103);
    EN   = 1'b1;
    MODE = 2'd1;
    exp_ctl(104, 2'b10);
    exp_aud(114, 1'b1);
    exp_aud(124, 1'b0);
    exp_aud(134, 1'b1);

    to_cyc(139);
    chk("steady_mid_audio", AUDIO, 1'b1);
    chk("steady_mid_active", ACTIVE, 1'b1);
    MODE = 2'd2;
    exp_aud(140, 1'b0);
    for (int i = 0; i < 17; i++) exp_aud(tt_cyc[i], (i % 2) == 0);
    exp_ctl(180, 2'b11);
    exp_ctl(220, 2'b10);
    exp_ctl(260, 2'b11);
    exp_aud(268, 1'b0);
    exp_ctl(268, 2'b00);

    to_cyc(267);
    chk("two_hi_audio", AUDIO, 1'b1);
    chk("two_hi_tone", TONE_HI, 1'b1);
    EN = 1'b0;

    to_cyc(277);
    chk("idle_active", ACTIVE, 1'b0);
    EN   = 1'b1;
    MODE = 2'd3;
    e0 = 278;
    exp_ctl(e0, 2'b11);
    exp_ctl(e0 + 100, 2'b10);
    for (int i = 0; i < 23; i++) exp_aud(e0 + wl_off[i], (i % 2) == 0);
    exp_aud(e0 + 165, 1'b0);
    exp_ctl(e0 + 165, 2'b00);

    to_cyc(e0 + 164);
    chk("wail_dn_audio", AUDIO, 1'b1);
    chk("wail_dn_tone", TONE_HI, 1'b0);
    chk("wail_dn_active", ACTIVE, 1'b1);
    RST = 1'b1;

    to_cyc(e0 + 165);
    chk("rst2_audio", AUDIO, 1'b0);
    chk("rst2_active", ACTIVE, 1'b0);
    RST = 1'b0;
    e2 = e0 + 166;
    exp_ctl(e2, 2'b11);
    exp_aud(e2 + 10, 1'b1);
    exp_aud(e2 + 20, 1'b0);
    exp_aud(e2 + 29, 1'b1);
    exp_aud(e2 + 38, 1'b0);
    exp_ctl(e2 + 45, 2'b00);

    to_cyc(e2 + 44);
    EN = 1'b0;
    to_cyc(e2 + 52);
    chk("end_audio", AUDIO, 1'b0);

    n_run++;
    if (q_ctl.size() != 0) begin
      n_fail++;
      $display("FAIL ctl_left: got %0d pending want 0", q_ctl.size());
    end
    n_run++;
    if (q_aud.size() != 0) begin
      n_fail++;
      $display("FAIL audio_left: got %0d pending want 0", q_aud.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
